// File: rtl/hamming_pkg.sv
// Shared types and constants for the streaming nearest-template search engine.
package hamming_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int CHUNK = 32'sd8;

  function automatic int num_chunks(input int n);
    return (n + CHUNK - 32'sd1) / CHUNK;
  endfunction

endpackage

// File: rtl/hamming_min_search_popcount.sv
// Combinational popcount of one CHUNK-wide slice of the XOR vector.
module popcount_chunk
  import hamming_pkg::*;
(
  input  logic [CHUNK-1:0] din,
  output logic [3:0]       cnt
);

  // Count set bits of the slice
  always_comb begin
    cnt = 4'd0;
    for (int i = 0; i < CHUNK; i++) begin
      cnt = cnt + {3'd0, din[i]};
    end
  end

endmodule

// File: rtl/hamming_min_search.sv
// Streams a frame of candidates against a stored template and reports the
// minimum Hamming distance, its beat index, a threshold match and beat count.
module hamming_min_search
  import hamming_pkg::*;
#(
  parameter int InN  = 40,
  parameter int OutN = 6,
  parameter int IdxN = 8
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic            ref_load,
  input  logic [InN-1:0]  ref_data,
  input  logic [OutN-1:0] threshold,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [InN-1:0]  in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OutN-1:0] out_dist,
  output logic [IdxN-1:0] out_idx,
  output logic            out_match,
  output logic [IdxN-1:0] out_count,
  output logic            busy
);

  localparam int NCH  = num_chunks(InN);
  localparam int PW   = NCH * CHUNK;
  localparam int SW   = $clog2(InN + 1) + 1;
  localparam int DMAX = (32'sd1 << OutN) - 32'sd1;

  state_t          state_r, state_n;
  logic            ready_r, ready_n, busy_r;
  logic [InN-1:0]  tmpl_r;
  logic [IdxN-1:0] cnt_r;
  logic [OutN-1:0] thr_r;
  logic            accept_s, first_s;
  logic [IdxN-1:0] bidx_s;

  logic            s1_valid_r, s1_last_r, s1_first_r;
  logic [IdxN-1:0] s1_idx_r;
  logic [InN-1:0]  s1_x_r;
  logic [PW-1:0]   pad_s;
  logic [3:0]      pc_s [NCH];
  logic            s2_valid_r, s2_last_r, s2_first_r;
  logic [IdxN-1:0] s2_idx_r;
  logic [3:0]      s2_pc_r [NCH];
  logic [SW-1:0]   sum_s;
  logic [OutN-1:0] dist_s, min_r;
  logic [IdxN-1:0] min_idx_r;
  logic            s3_done_r;

  logic            out_valid_r, out_match_r;
  logic [OutN-1:0] out_dist_r;
  logic [IdxN-1:0] out_idx_r, out_count_r;

  // A template load steals the cycle so no beat is compared against a half-written template
  assign in_ready  = ready_r & ~((state_r == IDLE) & ref_load);
  assign accept_s  = in_valid & in_ready;
  assign first_s   = (state_r == IDLE);
  assign bidx_s    = first_s ? '0 : cnt_r;
  assign out_valid = out_valid_r;
  assign out_dist  = out_dist_r;
  assign out_idx   = out_idx_r;
  assign out_match = out_match_r;
  assign out_count = out_count_r;
  assign busy      = busy_r;

  // Next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_n = in_last ? DRAIN : ACCUM;
        else          state_n = IDLE;
      end
      ACCUM: begin
        if (accept_s && in_last) state_n = DRAIN;
        else                     state_n = ACCUM;
      end
      DRAIN: begin
        if (s3_done_r) state_n = HOLD;
        else           state_n = DRAIN;
      end
      HOLD: begin
        if (out_ready) state_n = IDLE;
        else           state_n = HOLD;
      end
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == IDLE) || (state_n == ACCUM);
  end

  // State, template, beat counter and frame threshold
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_r <= IDLE;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      tmpl_r  <= '0;
      cnt_r   <= '0;
      thr_r   <= '0;
    end else begin
      state_r <= state_n;
      ready_r <= ready_n;
      busy_r  <= (state_n != IDLE);
      if (first_s && ref_load) tmpl_r <= ref_data;
      if (accept_s) begin
        if (first_s)            cnt_r <= IdxN'(32'd1);
        else if (cnt_r != '1)   cnt_r <= cnt_r + IdxN'(32'd1);
        if (first_s)            thr_r <= threshold;
      end
    end
  end

  assign pad_s = PW'(s1_x_r);

  for (genvar g = 0; g < NCH; g++) begin : g_chunk
    popcount_chunk u_pc (
      .din (pad_s[g*CHUNK +: CHUNK]),
      .cnt (pc_s[g])
    );
  end

  // Sum the chunk counts and saturate to the distance width
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < NCH; i++) begin
      sum_s = sum_s + SW'(s2_pc_r[i]);
    end
    if (int'(sum_s) > DMAX) dist_s = '1;
    else                    dist_s = OutN'(sum_s);
  end

  // Three-stage distance pipeline; strict less-than keeps the lowest index on ties
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_first_r <= 1'b0;
      s1_idx_r   <= '0;
      s1_x_r     <= '0;
      s2_valid_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_first_r <= 1'b0;
      s2_idx_r   <= '0;
      for (int i = 0; i < NCH; i++) s2_pc_r[i] <= 4'd0;
      min_r      <= '0;
      min_idx_r  <= '0;
      s3_done_r  <= 1'b0;
    end else begin
      s1_valid_r <= accept_s;
      s1_last_r  <= accept_s & in_last;
      s1_first_r <= accept_s & first_s;
      s1_idx_r   <= bidx_s;
      s1_x_r     <= in_data ^ tmpl_r;
      s2_valid_r <= s1_valid_r;
      s2_last_r  <= s1_last_r;
      s2_first_r <= s1_first_r;
      s2_idx_r   <= s1_idx_r;
      for (int i = 0; i < NCH; i++) s2_pc_r[i] <= pc_s[i];
      s3_done_r  <= s2_valid_r & s2_last_r;
      if (s2_valid_r && (s2_first_r || (dist_s < min_r))) begin
        min_r     <= dist_s;
        min_idx_r <= s2_idx_r;
      end
    end
  end

  // Result registers, frozen while the result is offered
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      out_valid_r <= 1'b0;
      out_dist_r  <= '0;
      out_idx_r   <= '0;
      out_match_r <= 1'b0;
      out_count_r <= '0;
    end else if (state_r == DRAIN && s3_done_r) begin
      out_valid_r <= 1'b1;
      out_dist_r  <= min_r;
      out_idx_r   <= min_idx_r;
      out_match_r <= (min_r <= thr_r);
      out_count_r <= cnt_r;
    end else if (state_r == HOLD && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: doc/hamming_min_search.md
# hamming_min_search

Streaming nearest-template search engine: compares a frame of candidate vectors against a stored reference template, computes the Hamming distance of every beat through a pipelined popcount, and reports the minimum distance, its beat index, a threshold-match flag and the beat count once per frame. It sits downstream of the pattern front-end, replacing single-pair distance registers where a whole candidate set must be scanned per decision.

## Interface
- InN, 40, candidate/template width in bits (≥ 1)
- OutN, 6, distance width; values above 2^OutN−1 saturate to all-ones
- IdxN, 8, beat index / count width
- Clock  input  1  rising-edge clock
- nReset  input  1  asynchronous, active-low reset
- ref_load  input  1  load ref_data as template; honoured only in IDLE
- ref_data  input  InN  template value
- threshold  input  OutN  match threshold, sampled on a frame's first accepted beat
- in_valid  input  1  candidate beat valid
- in_ready  output  1  engine accepts a beat
- in_data  input  InN  candidate vector
- in_last  input  1  final beat of frame
- out_valid  output  1  frame result valid
- out_ready  input  1  downstream consumes result
- out_dist  output  OutN  minimum distance in frame
- out_idx  output  IdxN  beat index of minimum (first beat = 0)
- out_match  output  1  out_dist ≤ sampled threshold
- out_count  output  IdxN  accepted beats in frame
- busy  output  1  state ≠ IDLE

## Operation
- Beat accepted when in_valid & in_ready. in_ready = 1 only in IDLE and ACCUM, and 0 in the cycle ref_load is honoured.
- States: IDLE → ACCUM on a non-last beat; IDLE/ACCUM → DRAIN on a last beat (single-beat frames allowed); DRAIN → HOLD when the last beat's distance has reached the compare stage; HOLD → IDLE on out_ready.
- Pipeline: S1 registers in_data ^ template with valid/last/index; S2 registers per-8-bit-chunk popcounts (ceil(InN/8) chunks, top chunk zero-padded); S3 sums the chunks with saturation to OutN and updates the running min/index.
- The first beat of a frame always loads min/index. Later beats replace them only on strictly smaller distance, so on ties the lowest index wins.
- The beat counter saturates at 2^IdxN−1. All beats beyond that share that index, and out_count holds at that value.
- ref_load outside IDLE is ignored. The template never changes mid-frame.
- out_dist, out_idx, out_match and out_count are stable from out_valid rise until the handshake completes.

## Timing
- Reset: out_valid, out_dist, out_idx, out_match, out_count, busy = 0, state = IDLE, template = 0. in_ready = 0 while nReset is low and rises on the first Clock edge after release.
- Latency: last beat accepted at edge t → out_valid = 1 after edge t+3.
- Throughput: 1 beat/cycle within a frame. The next frame's first beat is accepted no earlier than the cycle after the out_valid & out_ready handshake.
- out_valid & out_ready at edge t → out_valid = 0 and in_ready = 1 after t.
- Reset asserted mid-frame or mid-HOLD aborts the frame. All outputs return to their reset values asynchronously, and no partial result is emitted.

## Structure
- Package hamming_pkg holds:
  - state enum {IDLE, ACCUM, DRAIN, HOLD}
  - constant CHUNK = 8
  - function for chunk count ceil(InN/CHUNK)
- Sub-module popcount_chunk: an 8-bit combinational popcount, instantiated once per chunk in S2.

## Test plan
- Template 0, threshold 2, beats 40'hFF, 40'h1, 40'hFF_FFFF_FFFF(last): distances 8, 1, 40. Result out_dist = 1, out_idx = 1, out_count = 3, out_match = 1; out_valid rises 3 cycles after last.
- Tie: beats with distances 5, 3, 3(last) → out_idx = 1, out_dist = 3. Threshold 2 → out_match = 0.
- Backpressure: out_ready held 0 for 5 cycles. Required: out_valid stays 1, outputs stable, in_ready = 0 throughout; in_ready returns the cycle after the handshake.
- ref_load during ACCUM with new template 40'hF is ignored: distances still use the old template. The same ref_load in IDLE takes effect for the next frame.
- IdxN = 2, six beats with the minimum at beat 5 → out_idx = 3, out_count = 3. OutN = 3 with distance 40 → out_dist = 7.
- nReset pulsed low mid-frame after 2 beats → outputs zero, no out_valid. A following 1-beat frame gives out_count = 1, out_idx = 0.
